pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank.sv | 130 +++++++++++++
 tb/tb_pwm_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// -----------------------------------------------------------------------------
// pwm_bank: bank of CHANNELS PWM generators sharing one period counter.
//
// Period and duty values are loaded through a valid/ready handshake into a
// pending register set, then promoted to the active set either while idle or
// at the period boundary. This keeps changes glitch-free mid-period.
//
// Ports
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   enable         run request; low forces all channels to their inactive level
//   period_cycles  period in clk cycles (captured on handshake)
//   duty_cycles    per-channel high time, channel i at [i*CNT_W +: CNT_W]
//   update_valid   capture request for period_cycles/duty_cycles
//   update_ready   high when the pending buffer is empty
//   polarity       per-channel output inversion, applied live
//   pwm_out        registered PWM outputs
//   period_start   registered pulse on the first cycle of each period
// -----------------------------------------------------------------------------
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [CNT_W-1:0]          period_cycles,
    input  logic [CHANNELS*CNT_W-1:0] duty_cycles,
    input  logic                      update_valid,
    output logic                      update_ready,
    input  logic [CHANNELS-1:0]       polarity,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          act_period_q, act_period_d;
    logic [CHANNELS*CNT_W-1:0] act_duty_q, act_duty_d;
    logic [CNT_W-1:0]          pend_period_q, pend_period_d;
    logic [CHANNELS*CNT_W-1:0] pend_duty_q, pend_duty_d;
    logic                      pend_valid_q, pend_valid_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      ps_q, ps_d;

    logic run;
    logic capture;
    logic boundary;
    logic xfer;

    // Unsigned compare of the shared counter against one channel's duty.
    function automatic logic duty_active(input logic [CNT_W-1:0] cnt,
                                         input logic [CNT_W-1:0] duty);
        return cnt < duty;
    endfunction

    always_comb begin
        run      = (state_q == RUN);
        capture  = update_valid && !pend_valid_q;
        boundary = run && (cnt_q == (act_period_q - ONE));
        // Capture only happens when pending is empty, so a transfer always
        // uses the pre-capture pending contents.
        xfer     = pend_valid_q && (!run || boundary);

        act_period_d  = xfer ? pend_period_q : act_period_q;
        act_duty_d    = xfer ? pend_duty_q   : act_duty_q;
        pend_period_d = capture ? period_cycles : pend_period_q;
        pend_duty_d   = capture ? duty_cycles   : pend_duty_q;

        pend_valid_d = pend_valid_q;
        if (capture) begin
            pend_valid_d = 1'b1;
        end else if (xfer) begin
            pend_valid_d = 1'b0;
        end

        // State follows the post-transfer period so a zero period loaded at a
        // boundary drops straight to IDLE.
        state_d = (enable && (act_period_d != '0)) ? RUN : IDLE;

        // Counter restarts at 0 on wrap, while idle, and on the first RUN cycle.
        if ((state_d == IDLE) || !run || boundary) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = polarity[i] ^ (run && duty_active(cnt_q, act_duty_q[i*CNT_W +: CNT_W]));
        end
        ps_d = run && (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            act_period_q  <= '0;
            act_duty_q    <= '0;
            pend_period_q <= '0;
            pend_duty_q   <= '0;
            pend_valid_q  <= 1'b0;
            pwm_q         <= '0;
            ps_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            act_period_q  <= act_period_d;
            act_duty_q    <= act_duty_d;
            pend_period_q <= pend_period_d;
            pend_duty_q   <= pend_duty_d;
            pend_valid_q  <= pend_valid_d;
            pwm_q         <= pwm_d;
            ps_q          <= ps_d;
        end
    end

    assign update_ready = !pend_valid_q;
    assign pwm_out      = pwm_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_bank: directed testbench for pwm_bank (CHANNELS=4, CNT_W=16).
// Index k counts falling edges; at k=0 the outputs first reflect counter 0.
// -----------------------------------------------------------------------------
module tb_pwm_bank;

    localparam int CH = 4;
    localparam int CW = 16;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [CW-1:0]    period_cycles;
    logic [CH*CW-1:0] duty_cycles;
    logic             update_valid;
    logic             update_ready;
    logic [CH-1:0]    polarity;
    logic [CH-1:0]    pwm_out;
    logic             period_start;

    int tests;
    int failed;
    int k;
    int p;
    int d1;
    logic [3:0] exp_pwm;
    logic       exp_ps;

    pwm_bank #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .period_cycles (period_cycles),
        .duty_cycles   (duty_cycles),
        .update_valid  (update_valid),
        .update_ready  (update_ready),
        .polarity      (polarity),
        .pwm_out       (pwm_out),
        .period_start  (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests         = 0;
        failed        = 0;
        rst_n         = 1'b0;
        enable        = 1'b0;
        period_cycles = '0;
        duty_cycles   = '0;
        update_valid  = 1'b0;
        polarity      = '0;

        // Reset state, before any clock edge
        #1;
        check("rst pwm", 32'(pwm_out), 32'h0);
        check("rst ps", 32'(period_start), 32'h0);
        check("rst ready", 32'(update_ready), 32'h1);

        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        polarity = 4'b1010;
        @(negedge clk);
        check("idle pol pwm", 32'(pwm_out), 32'hA);
        check("idle pol ps", 32'(period_start), 32'h0);
        polarity = 4'b0000;
        @(negedge clk);
        check("idle pwm", 32'(pwm_out), 32'h0);

        // Load period 10, duties {ch3=12, ch2=10, ch1=3, ch0=0}
        period_cycles = 16'd10;
        duty_cycles   = {16'd12, 16'd10, 16'd3, 16'd0};
        update_valid  = 1'b1;
        enable        = 1'b1;

        for (int n = 1; n <= 94; n++) begin
            @(negedge clk);
            k = n - 3;
            if (n == 1) begin
                check("cap ready", 32'(update_ready), 32'h0);
                update_valid = 1'b0;
            end
            if (n == 2) begin
                check("pre-run pwm", 32'(pwm_out), 32'h0);
                check("pre-run ps", 32'(period_start), 32'h0);
                check("xfer ready", 32'(update_ready), 32'h1);
            end
            if (k >= 0) begin
                if (k >= 55 && k <= 60) begin
                    exp_pwm = 4'b0000;
                    exp_ps  = 1'b0;
                end else if (k >= 81) begin
                    exp_pwm = 4'b0110;
                    exp_ps  = 1'b1;
                end else begin
                    p  = (k <= 54) ? (k % 10) : ((k - 61) % 10);
                    d1 = (k < 30) ? 3 : 7;
                    exp_pwm = {1'b1, 1'b1, (p < d1), 1'b0};
                    if (k >= 41 && k <= 51) exp_pwm[1] = ~exp_pwm[1];
                    exp_ps = (p == 0);
                end
                check($sformatf("pwm k=%0d", k), 32'(pwm_out), 32'(exp_pwm));
                check($sformatf("ps k=%0d", k), 32'(period_start), 32'(exp_ps));
            end
            if (k >= 24 && k <= 28) check($sformatf("ready k=%0d", k), 32'(update_ready), 32'h0);
            if (k >= 76 && k <= 79) check($sformatf("ready k=%0d", k), 32'(update_ready), 32'h0);
            if (k == 23 || k == 29 || k == 75 || k == 80 || k == 90)
                check($sformatf("ready k=%0d", k), 32'(update_ready), 32'h1);
            if (k == 91) check("ready k=91", 32'(update_ready), 32'h0);

            // Stimulus applied after sampling at this k
            case (k)
                23: begin
                    duty_cycles  = {16'd12, 16'd10, 16'd7, 16'd0};
                    update_valid = 1'b1;
                end
                24: update_valid = 1'b0;
                40: polarity = 4'b0010;
                51: polarity = 4'b0000;
                53: enable = 1'b0;
                59: enable = 1'b1;
                75: begin
                    period_cycles = 16'd1;
                    duty_cycles   = {16'd0, 16'd1, 16'd1, 16'd0};
                    update_valid  = 1'b1;
                end
                76: update_valid = 1'b0;
                90: begin
                    period_cycles = 16'd10;
                    duty_cycles   = {16'd12, 16'd10, 16'd3, 16'd0};
                    update_valid  = 1'b1;
                end
                default: ;
            endcase
        end

        // Asynchronous reset between edges with an update pending
        update_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst pwm", 32'(pwm_out), 32'h0);
        check("async rst ps", 32'(period_start), 32'h0);
        check("async rst ready", 32'(update_ready), 32'h1);

        @(negedge clk);
        rst_n    = 1'b1;
        polarity = 4'b0101;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("post-rst pol %0d", n), 32'(pwm_out), 32'h5);
        end
        polarity = 4'b0000;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check($sformatf("post-rst pwm %0d", n), 32'(pwm_out), 32'h0);
            check($sformatf("post-rst ps %0d", n), 32'(period_start), 32'h0);
            check($sformatf("post-rst ready %0d", n), 32'(update_ready), 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
